// File: rtl/tc_encoder8_seq.sv
// Sequential 8-to-3 encoder: sticky pending set of request pulses, one index presented at a time.
// Latency: request-to-valid 2 cycles; one index per cycle while ack stays high.
// Backpressure: valid/ack handshake; sel holds while valid=1 and ack=0; dis stalls presentation
// while requests keep accumulating. Optional round-robin selection: TC_ENCODER8_RR_EN.
module tc_encoder8_seq #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dis,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in5,
    input  logic in6,
    input  logic in7,
    input  logic ack,
    output logic sel0,
    output logic sel1,
    output logic sel2,
    output logic valid,
    output logic multi
);

    logic [7:0] req;
    logic [7:0] pending;
    logic [7:0] clr;
    logic [7:0] cand;
    logic [2:0] sel;
    logic [2:0] pick;
    logic       found;
    logic       load;

    assign req  = {in7, in6, in5, in4, in3, in2, in1, in0};
    assign clr  = (valid && ack) ? (8'd1 << sel) : 8'd0;
    // Candidates come from the register only; same-cycle requests wait one edge.
    assign cand = pending & ~clr;
    assign load = !dis && (!valid || ack);

`ifdef TC_ENCODER8_RR_EN
    logic [2:0] ptr;

    always_comb begin
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && cand[ptr + 3'(i) + 3'd1]) begin
                pick  = ptr + 3'(i) + 3'd1;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 3'd7;
        end else if (load && found) begin
            ptr <= pick;
        end
    end
`else
    always_comb begin
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && cand[i]) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 8'd0;
            sel     <= 3'd0;
            valid   <= 1'b0;
        end else begin
            pending <= cand | req;
            if (dis) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= found;
                if (found) begin
                    sel <= pick;
                end
            end
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign multi = |(pending & (pending - 8'd1));
    assign sel0  = sel[0];
    assign sel1  = sel[1];
    assign sel2  = sel[2];

endmodule

// File: tb/tb_tc_encoder8_seq.sv
// Bench for tc_encoder8_seq: directed scenarios with constant expectations, then a random
// phase scored against a behavioural reference; expected outputs queued at drive time.
module tb_tc_encoder8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dis = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] inp = 8'd0;
    logic       sel0, sel1, sel2, valid, multi;
    logic [2:0] sel;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] exp_q[$];

    // reference state for the random phase
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_sel;
    logic [2:0] m_ptr;

    assign sel = {sel2, sel1, sel0};

    always #5 clk = ~clk;

    tc_encoder8_seq #(.UUID(0), .NAME("dut")) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dis   (dis),
        .in0   (inp[0]),
        .in1   (inp[1]),
        .in2   (inp[2]),
        .in3   (inp[3]),
        .in4   (inp[4]),
        .in5   (inp[5]),
        .in6   (inp[6]),
        .in7   (inp[7]),
        .ack   (ack),
        .sel0  (sel0),
        .sel1  (sel1),
        .sel2  (sel2),
        .valid (valid),
        .multi (multi)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after the edge, then score them.
    task automatic step(input string tag, input logic [7:0] r, input logic a, input logic d,
                        input logic ev, input logic [2:0] es, input logic em);
        logic [4:0] e;
        inp = r;
        ack = a;
        dis = d;
        exp_q.push_back({ev, es, em});
        @(posedge clk);
        #1;
        inp = 8'd0;
        ack = 1'b0;
        dis = 1'b0;
        e = exp_q.pop_front();
        chk({tag, ".valid"}, 8'(valid), 8'(e[4]));
        if (e[4]) chk({tag, ".sel"}, 8'(sel), 8'(e[3:1]));
        chk({tag, ".multi"}, 8'(multi), 8'(e[0]));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.valid", 8'(valid), 8'd0);
        chk("rst.sel", 8'(sel), 8'd0);
        chk("rst.multi", 8'(multi), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_pend  = 8'd0;
        m_valid = 1'b0;
        m_sel   = 3'd0;
        m_ptr   = 3'd7;
    endtask

    // Behavioural next-state for one cycle of random stimulus.
    task automatic model_step(input logic [7:0] r, input logic a, input logic d);
        logic [7:0] cl;
        logic [7:0] cd;
        logic       hit;
        logic [2:0] idx;
        cl  = (m_valid && a) ? (8'd1 << m_sel) : 8'd0;
        cd  = m_pend & ~cl;
        hit = 1'b0;
        if (d) begin
            m_valid = 1'b0;
        end else if (!m_valid || a) begin
`ifdef TC_ENCODER8_RR_EN
            for (int k = 1; k <= 8; k++) begin
                idx = 3'((int'(m_ptr) + k) % 8);
                if (!hit && cd[idx]) begin
                    hit   = 1'b1;
                    m_sel = idx;
                    m_ptr = idx;
                end
            end
`else
            for (int k = 7; k >= 0; k--) begin
                if (cd[k]) begin
                    hit   = 1'b1;
                    m_sel = 3'(k);
                end
            end
`endif
            m_valid = hit;
        end
        m_pend = cd | r;
    endtask

    initial begin
        logic [7:0] r;
        logic       a, d;

        #3;
        chk("por.valid", 8'(valid), 8'd0);
        chk("por.sel", 8'(sel), 8'd0);
        chk("por.multi", 8'(multi), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef TC_ENCODER8_RR_EN
        // single request, hold, then accept
        step("single0", 8'h20, 0, 0, 0, 0, 0);
        step("single1", 8'h00, 0, 0, 1, 5, 0);
        for (int i = 0; i < 4; i++) step("hold", 8'h00, 0, 0, 1, 5, 0);
        step("accept", 8'h00, 1, 0, 0, 0, 0);
        // priority burst with ack held
        step("burst0", 8'h4C, 1, 0, 0, 0, 1);
        step("burst1", 8'h00, 1, 0, 1, 2, 1);
        step("burst2", 8'h00, 1, 0, 1, 3, 1);
        step("burst3", 8'h00, 1, 0, 1, 6, 0);
        step("burst4", 8'h00, 1, 0, 0, 0, 0);
        // re-arm collision on the bit being cleared
        step("rearm0", 8'h10, 0, 0, 0, 0, 0);
        step("rearm1", 8'h00, 0, 0, 1, 4, 0);
        step("rearm2", 8'h10, 1, 0, 0, 0, 0);
        step("rearm3", 8'h00, 0, 0, 1, 4, 0);
        step("rearm4", 8'h00, 1, 0, 0, 0, 0);
        // disable with same-cycle ack, accumulate while disabled
        step("dis0", 8'h81, 0, 0, 0, 0, 1);
        step("dis1", 8'h00, 0, 0, 1, 0, 1);
        step("dis2", 8'h00, 1, 1, 0, 0, 0);
        step("dis3", 8'h02, 0, 1, 0, 0, 1);
        step("dis4", 8'h00, 0, 1, 0, 0, 1);
        step("dis5", 8'h00, 0, 0, 1, 1, 1);
        step("dis6", 8'h00, 1, 0, 1, 7, 0);
        step("dis7", 8'h00, 1, 0, 0, 0, 0);
        // mid-operation reset with pending=0xA5 and valid=1
        step("pre0", 8'hA5, 0, 0, 0, 0, 1);
        step("pre1", 8'h00, 0, 0, 1, 0, 1);
`else
        // park ptr at 2, then the burst walks 3,6,2
        step("park0", 8'h04, 0, 0, 0, 0, 0);
        step("park1", 8'h00, 0, 0, 1, 2, 0);
        step("park2", 8'h00, 1, 0, 0, 0, 0);
        step("rrb0", 8'h4C, 1, 0, 0, 0, 1);
        step("rrb1", 8'h00, 1, 0, 1, 3, 1);
        step("rrb2", 8'h00, 1, 0, 1, 6, 1);
        step("rrb3", 8'h00, 1, 0, 1, 2, 0);
        step("rrb4", 8'h00, 1, 0, 0, 0, 0);
        // park ptr at 6, then 0x41 wraps to 0 before 6
        step("wrap0", 8'h40, 0, 0, 0, 0, 0);
        step("wrap1", 8'h00, 0, 0, 1, 6, 0);
        step("wrap2", 8'h00, 1, 0, 0, 0, 0);
        step("wrap3", 8'h41, 0, 0, 0, 0, 1);
        step("wrap4", 8'h00, 1, 0, 1, 0, 1);
        step("wrap5", 8'h00, 1, 0, 1, 6, 0);
        step("wrap6", 8'h00, 1, 0, 0, 0, 0);
        step("pre0", 8'hA5, 0, 0, 0, 0, 1);
        step("pre1", 8'h00, 0, 0, 1, 0, 1);
`endif
        do_reset();
        step("post0", 8'h00, 0, 0, 0, 0, 0);
        step("post1", 8'h00, 1, 0, 0, 0, 0);

        // random phase against the reference
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            a = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 9) == 0);
            model_step(r, a, d);
            step("rand", r, a, d, m_valid, m_sel, $countones(m_pend) >= 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
